data_mem_ctrl: RTL and testbench
================================

# data_mem_ctrl

Parametrised data-memory controller that replaces the fixed 256×32 single-cycle data memory for the multicycle and pipelined CPU generations. It serves byte, halfword and word loads and stores, with sign or zero extension, through a valid/ready request and response handshake. Response latency is configurable. Misaligned and out-of-range accesses are flagged instead of silently wrapping. An optional registered debug read port serves the DBU.

## Interface
Parameters:
- DEPTH_LOG2, 8: log2 of the number of 32-bit words; byte address space is 2^(DEPTH_LOG2+2).
- LATENCY, 1: extra wait cycles between acceptance and response; legal range 0..15.

Ports:
- clk  in  1  single clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  controller can accept a request this cycle.
- req_we  in  1  1 = store, 0 = load.
- req_size  in  2  access size: 00 byte, 01 halfword, 10 word; 11 is illegal and raises an error.
- req_unsigned  in  1  load zero-extends when 1 and sign-extends when 0; ignored for word loads and for stores.
- addr  in  32  byte address, little-endian.
- wdata  in  32  store data; byte and halfword stores use the low bits.
- resp_valid  out  1  one-cycle response strobe.
- rdata  out  32  load result, held until the next response.
- resp_err  out  1  error flag qualified by resp_valid.
- dbg_addr  in  DEPTH_LOG2  debug word index.
- dbg_data  out  32  debug word.

## Operation
- State machine has three states: IDLE, BUSY and RESP. Reset enters IDLE.
- Reset values: req_ready=1, resp_valid=0, resp_err=0, rdata=0, dbg_data=0, wait counter=0.
- Reset does not clear the memory array; its contents are undefined until written.
- IDLE:
  - req_ready=1.
  - When req_valid is high, latch we, size, unsigned, addr and wdata.
  - If LATENCY>0, load the counter with LATENCY and go to BUSY.
  - If LATENCY=0, go straight to RESP.
- BUSY:
  - req_ready=0 and the counter decrements each cycle.
  - When the counter reaches 1, go to RESP.
- The access is committed on the clock edge that enters RESP:
  - A store merges the byte lanes selected by addr[1:0] and size.
  - A load extracts the selected lanes, extends them, and registers the result into rdata.
- RESP:
  - resp_valid=1 for exactly one cycle, then return to IDLE.
  - req_ready=0 in RESP.
- Error conditions, evaluated on the latched request:
  - Halfword with addr[0]≠0.
  - Word with addr[1:0]≠0.
  - req_size=11.
  - Any set bit in addr[31:DEPTH_LOG2+2].
- On error: no write occurs, rdata=0 and resp_err=1. Otherwise resp_err=0.
- Stores return rdata=0.
- Word index is addr[DEPTH_LOG2+1:2]. Addresses never wrap.

## Timing
- A request is accepted at rising edge T when req_valid=1 and req_ready=1.
- resp_valid is high during cycle T+1+LATENCY.
- req_ready rises again in cycle T+2+LATENCY. Peak throughput is one access per LATENCY+2 cycles.
- Inputs are sampled only at acceptance; they may change freely afterwards.
- Reset asserted mid-operation: the FSM returns to IDLE immediately and no response is issued. A store whose commit edge has not yet occurred is not performed; a committed store persists.
- Debug port: dbg_data is registered and shows mem[dbg_addr] one cycle after dbg_addr is applied.
- Debug read of a word being stored on the same edge returns the old value.

## Configuration
- DMEM_DBG_PORT_EN defined: the debug port is present as described under Timing.
- DMEM_DBG_PORT_EN undefined: dbg_data is tied to 0, dbg_addr is ignored, and no debug read logic is built. The port list is unchanged.

## Test plan
All scenarios use DEPTH_LOG2=8 and LATENCY=2.
- Store word 0x12345678 to 0x10 accepted at T → resp_valid at T+3 with err=0. Load word 0x10 → rdata 0x12345678 and resp_valid exactly 3 cycles after acceptance.
- Store byte 0xAB to 0x13 → load word 0x10 returns 0xAB345678. Load signed byte 0x13 returns 0xFFFFFFAB. Load unsigned byte 0x13 returns 0x000000AB.
- Store halfword 0x8001 to 0x12 → load word 0x10 returns 0x80015678. Load signed halfword 0x12 returns 0xFFFF8001. Load unsigned halfword 0x12 returns 0x00008001.
- Load word 0x11 → resp_err=1 and rdata=0. Store word 0xFFFFFFFF to 0x11 → resp_err=1, and a later load word 0x10 still returns 0x80015678.
- Load word at 0x400 → resp_err=1. Store at 0x400 followed by load word 0x000 shows no aliasing.
- Store word 0xDEADBEEF to 0x20, with rst_n pulsed low the cycle after acceptance → no resp_valid and req_ready=1 after release. With DMEM_DBG_PORT_EN: dbg_addr=4 gives dbg_data 0x80015678 one cycle later.

Source files
------------

// File: rtl/data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// data_mem_ctrl
//
// Purpose:
//   Parametrised data-memory controller for the multicycle and pipelined CPUs.
//   Serves byte / halfword / word loads and stores (little-endian) through a
//   valid/ready request handshake and a one-cycle response strobe. Response
//   latency is set by LATENCY. Misaligned, illegal-size and out-of-range
//   accesses are flagged with resp_err instead of wrapping.
//
// Parameters:
//   DEPTH_LOG2 - log2 of the number of 32-bit words (byte space 2^(DEPTH_LOG2+2))
//   LATENCY    - extra wait cycles between acceptance and response (0..15)
//
// Ports:
//   clk, rst_n    - clock, asynchronous active-low reset
//   req_valid/req_ready - request handshake
//   req_we        - 1 = store, 0 = load
//   req_size      - 00 byte, 01 halfword, 10 word, 11 illegal
//   req_unsigned  - zero-extend sub-word loads when 1, sign-extend when 0
//   addr, wdata   - byte address and store data
//   resp_valid    - one-cycle response strobe
//   rdata         - load result (0 for stores and errors), held between responses
//   resp_err      - error flag, qualified by resp_valid
//   dbg_addr      - debug word index
//   dbg_data      - registered debug word
//
// Configuration:
//   DMEM_DBG_PORT_EN - when defined, dbg_data shows mem[dbg_addr] one cycle
//                      after dbg_addr is applied; when undefined dbg_data is 0.
// ---------------------------------------------------------------------------
module data_mem_ctrl #(
    parameter int DEPTH_LOG2 = 8,
    parameter int LATENCY    = 1
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_we,
    input  logic [1:0]            req_size,
    input  logic                  req_unsigned,
    input  logic [31:0]           addr,
    input  logic [31:0]           wdata,
    output logic                  resp_valid,
    output logic [31:0]           rdata,
    output logic                  resp_err,
    input  logic [DEPTH_LOG2-1:0] dbg_addr,
    output logic [31:0]           dbg_data
);

    localparam int         DEPTH = 1 << DEPTH_LOG2;
    localparam logic [3:0] LAT   = 4'(LATENCY);

    typedef enum logic [1:0] {
        IDLE,
        BUSY,
        RESP
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic            we_q;
    logic [1:0]      size_q;
    logic            uns_q;
    logic [31:0]     addr_q;
    logic [31:0]     wdata_q;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;

    logic [31:0]     mem [DEPTH];

    logic            curWe;
    logic [1:0]      curSize;
    logic            curUns;
    logic [31:0]     curAddr;
    logic [31:0]     curWdata;
    logic            commit;
    logic            accessErr;
    logic [DEPTH_LOG2-1:0] wordIdx;
    logic [3:0]      byteEn;
    logic [31:0]     wdataShifted;
    logic [31:0]     readShifted;
    logic [31:0]     loadValue;

    // With LATENCY=0 the access commits on the acceptance edge itself, before
    // the request registers hold it, so the request is taken straight from
    // the ports while IDLE and from the latched copy otherwise.
    always_comb begin
        curWe    = we_q;
        curSize  = size_q;
        curUns   = uns_q;
        curAddr  = addr_q;
        curWdata = wdata_q;
        if (state_q == IDLE) begin
            curWe    = req_we;
            curSize  = req_size;
            curUns   = req_unsigned;
            curAddr  = addr;
            curWdata = wdata;
        end
    end

    // Commit happens on the edge that moves the FSM into RESP. Gating with
    // rst_n keeps a store from landing while reset holds the FSM in IDLE.
    assign commit = rst_n &&
                    (((state_q == IDLE) && req_valid && (LATENCY == 0)) ||
                     ((state_q == BUSY) && (cnt_q == 4'd1)));

    // Error decode, lane selection and load extraction for the current request.
    always_comb begin
        accessErr = ((curAddr >> (DEPTH_LOG2 + 2)) != 32'd0);
        byteEn    = 4'b0000;
        case (curSize)
            2'b00: byteEn = 4'b0001;
            2'b01: begin
                byteEn = 4'b0011;
                if (curAddr[0]) accessErr = 1'b1;
            end
            2'b10: begin
                byteEn = 4'b1111;
                if (curAddr[1:0] != 2'b00) accessErr = 1'b1;
            end
            default: accessErr = 1'b1;
        endcase
        byteEn       = byteEn << curAddr[1:0];
        wordIdx      = curAddr[DEPTH_LOG2+1:2];
        wdataShifted = curWdata << {curAddr[1:0], 3'b000};
        readShifted  = mem[wordIdx] >> {curAddr[1:0], 3'b000};
        case (curSize)
            2'b00:   loadValue = {{24{~curUns & readShifted[7]}}, readShifted[7:0]};
            2'b01:   loadValue = {{16{~curUns & readShifted[15]}}, readShifted[15:0]};
            default: loadValue = readShifted;
        endcase
    end

    // Next-state logic for the IDLE -> BUSY -> RESP -> IDLE sequence plus the
    // response registers, which only change on a commit edge.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    if (LATENCY == 0) begin
                        state_d = RESP;
                    end else begin
                        state_d = BUSY;
                        cnt_d   = LAT;
                    end
                end
            end
            BUSY: begin
                cnt_d = cnt_q - 4'd1;
                if (cnt_q == 4'd1) state_d = RESP;
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (commit) begin
            err_d   = accessErr;
            rdata_d = (accessErr || curWe) ? 32'd0 : loadValue;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Request capture at acceptance; inputs are free to change afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            we_q    <= 1'b0;
            size_q  <= 2'b00;
            uns_q   <= 1'b0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
        end else if ((state_q == IDLE) && req_valid) begin
            we_q    <= req_we;
            size_q  <= req_size;
            uns_q   <= req_unsigned;
            addr_q  <= addr;
            wdata_q <= wdata;
        end
    end

    // Memory array is intentionally not reset; only enabled byte lanes are written.
    always_ff @(posedge clk) begin
        if (commit && curWe && !accessErr) begin
            for (int i = 0; i < 4; i++) begin
                if (byteEn[i]) mem[wordIdx][8*i +: 8] <= wdataShifted[8*i +: 8];
            end
        end
    end

`ifdef DMEM_DBG_PORT_EN
    // Registered debug read; a same-edge store is not visible until next cycle.
    logic [31:0] dbg_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dbg_q <= 32'd0;
        end else begin
            dbg_q <= mem[dbg_addr];
        end
    end

    assign dbg_data = dbg_q;
`else
    logic dbg_unused;

    assign dbg_unused = ^dbg_addr;
    assign dbg_data   = 32'd0;
`endif

    assign req_ready  = (state_q == IDLE);
    assign resp_valid = (state_q == RESP);
    assign rdata      = rdata_q;
    assign resp_err   = err_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// ---------------------------------------------------------------------------
// tb_data_mem_ctrl
//
// Self-checking bench for data_mem_ctrl (DEPTH_LOG2=8, LATENCY=2). A byte-array
// reference model predicts load data, error flags and memory contents;
// directed scenarios are followed by randomized accesses.
// ---------------------------------------------------------------------------
module tb_data_mem_ctrl;

    localparam int DL     = 8;
    localparam int LAT    = 2;
    localparam int NBYTES = 1 << (DL + 2);

    logic          clk = 1'b0;
    logic          rst_n;
    logic          req_valid;
    logic          req_ready;
    logic          req_we;
    logic [1:0]    req_size;
    logic          req_unsigned;
    logic [31:0]   addr;
    logic [31:0]   wdata;
    logic          resp_valid;
    logic [31:0]   rdata;
    logic          resp_err;
    logic [DL-1:0] dbg_addr;
    logic [31:0]   dbg_data;

    int checks = 0;
    int errors = 0;

    logic [7:0] mdl [NBYTES];

    data_mem_ctrl #(
        .DEPTH_LOG2(DL),
        .LATENCY   (LAT)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_we      (req_we),
        .req_size    (req_size),
        .req_unsigned(req_unsigned),
        .addr        (addr),
        .wdata       (wdata),
        .resp_valid  (resp_valid),
        .rdata       (rdata),
        .resp_err    (resp_err),
        .dbg_addr    (dbg_addr),
        .dbg_data    (dbg_data)
    );

    always #5 clk = ~clk;

    // Single comparison point: counts every check and reports mismatches.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference model: memory as a flat little-endian byte array.
    task automatic modelAccess(input logic we, input logic [1:0] size, input logic uns,
                               input logic [31:0] a, input logic [31:0] wd,
                               output logic [31:0] rd, output logic err);
        int n;
        logic [31:0] v;
        n   = 1 << size;
        err = (size == 2'b11) || (a >= NBYTES) || ((a % n) != 0);
        rd  = 32'd0;
        if (!err) begin
            if (we) begin
                for (int i = 0; i < n; i++) mdl[int'(a) + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++) v = v | (32'(mdl[int'(a) + i]) << (8 * i));
                if (!uns && n < 4 && v[8*n-1]) v = v | (32'hFFFF_FFFF << (8 * n));
                rd = v;
            end
        end
    endtask

    function automatic logic [31:0] modelWord(input int idx);
        return {mdl[4*idx+3], mdl[4*idx+2], mdl[4*idx+1], mdl[4*idx]};
    endfunction

    // One complete transaction: handshake, latency, response data and error.
    task automatic applyStimulus(input string tag, input logic we, input logic [1:0] size,
                                 input logic uns, input logic [31:0] a, input logic [31:0] wd);
        logic [31:0] expRd;
        logic        expErr;
        int          k;
        modelAccess(we, size, uns, a, wd, expRd, expErr);
        @(negedge clk);
        checkOutput({tag, "/ready_idle"}, req_ready, 1'b1);
        req_valid    = 1'b1;
        req_we       = we;
        req_size     = size;
        req_unsigned = uns;
        addr         = a;
        wdata        = wd;
        @(posedge clk);
        #1;
        req_valid    = 1'b0;
        req_we       = 1'($urandom);
        req_size     = 2'($urandom);
        req_unsigned = 1'($urandom);
        addr         = $urandom;
        wdata        = $urandom;
        k = 0;
        while (!resp_valid && k < 20) begin
            checkOutput({tag, "/ready_busy"}, req_ready, 1'b0);
            @(posedge clk);
            #1;
            k++;
        end
        checkOutput({tag, "/latency"}, k, LAT);
        checkOutput({tag, "/rdata"}, rdata, expRd);
        checkOutput({tag, "/err"}, resp_err, expErr);
        @(posedge clk);
        #1;
        checkOutput({tag, "/valid_drop"}, resp_valid, 1'b0);
        checkOutput({tag, "/ready_back"}, req_ready, 1'b1);
        checkOutput({tag, "/rdata_hold"}, rdata, expRd);
    endtask

    initial begin
        #1_000_000;
        $display("[TB] FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "[TB] simulation did not finish");
    end

    initial begin
        logic [31:0] a;
        logic [1:0]  sz;
        int          n;

        rst_n        = 1'b0;
        req_valid    = 1'b0;
        req_we       = 1'b0;
        req_size     = 2'b00;
        req_unsigned = 1'b0;
        addr         = 32'd0;
        wdata        = 32'd0;
        dbg_addr     = '0;

        #23;
        checkOutput("reset/ready", req_ready, 1'b1);
        checkOutput("reset/valid", resp_valid, 1'b0);
        checkOutput("reset/err", resp_err, 1'b0);
        checkOutput("reset/rdata", rdata, 32'd0);
        checkOutput("reset/dbg", dbg_data, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        $display("[TB] filling memory");
        for (int w = 0; w < (1 << DL); w++) applyStimulus("fill", 1'b1, 2'b10, 1'b0, 32'(4 * w), $urandom);

        $display("[TB] directed scenarios");
        applyStimulus("sw_10",      1'b1, 2'b10, 1'b0, 32'h10, 32'h1234_5678);
        applyStimulus("lw_10",      1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        applyStimulus("sb_13",      1'b1, 2'b00, 1'b0, 32'h13, 32'h0000_00AB);
        applyStimulus("lw_10b",     1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        applyStimulus("lb_13",      1'b0, 2'b00, 1'b0, 32'h13, 32'h0);
        applyStimulus("lbu_13",     1'b0, 2'b00, 1'b1, 32'h13, 32'h0);
        applyStimulus("sh_12",      1'b1, 2'b01, 1'b0, 32'h12, 32'h0000_8001);
        applyStimulus("lw_10h",     1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        applyStimulus("lh_12",      1'b0, 2'b01, 1'b0, 32'h12, 32'h0);
        applyStimulus("lhu_12",     1'b0, 2'b01, 1'b1, 32'h12, 32'h0);
        checkOutput("const/word10", modelWord(4), 32'h8001_5678);
        applyStimulus("lw_11",      1'b0, 2'b10, 1'b0, 32'h11, 32'h0);
        applyStimulus("sw_11",      1'b1, 2'b10, 1'b0, 32'h11, 32'hFFFF_FFFF);
        applyStimulus("lw_10e",     1'b0, 2'b10, 1'b0, 32'h10, 32'h0);
        applyStimulus("lw_400",     1'b0, 2'b10, 1'b0, 32'h400, 32'h0);
        applyStimulus("sw_400",     1'b1, 2'b10, 1'b0, 32'h400, 32'hCAFE_F00D);
        applyStimulus("lw_000",     1'b0, 2'b10, 1'b0, 32'h000, 32'h0);
        applyStimulus("size11",     1'b0, 2'b11, 1'b0, 32'h20, 32'h0);
        applyStimulus("lh_odd",     1'b0, 2'b01, 1'b0, 32'h21, 32'h0);

        $display("[TB] reset during a pending store");
        @(negedge clk);
        req_valid = 1'b1;
        req_we    = 1'b1;
        req_size  = 2'b10;
        addr      = 32'h20;
        wdata     = 32'hDEAD_BEEF;
        @(posedge clk);
        #1;
        req_valid = 1'b0;
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        checkOutput("rst/valid_low", resp_valid, 1'b0);
        checkOutput("rst/ready_low", req_ready, 1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(posedge clk);
            #1;
            checkOutput("rst/no_resp", resp_valid, 1'b0);
            checkOutput("rst/ready", req_ready, 1'b1);
        end
        applyStimulus("lw_20_after_rst", 1'b0, 2'b10, 1'b0, 32'h20, 32'h0);

`ifdef DMEM_DBG_PORT_EN
        @(negedge clk);
        dbg_addr = DL'(4);
        @(posedge clk);
        #1;
        checkOutput("dbg/word4", dbg_data, modelWord(4));
        checkOutput("dbg/const", dbg_data, 32'h8001_5678);
        for (int d = 0; d < 8; d++) begin
            @(negedge clk);
            dbg_addr = DL'($urandom);
            @(posedge clk);
            #1;
            checkOutput("dbg/rand", dbg_data, modelWord(int'(dbg_addr)));
        end
`else
        for (int d = 0; d < 4; d++) begin
            @(negedge clk);
            dbg_addr = DL'($urandom);
            @(posedge clk);
            #1;
            checkOutput("dbg/tied", dbg_data, 32'd0);
        end
`endif

        $display("[TB] randomized accesses");
        for (int t = 0; t < 300; t++) begin
            sz = ($urandom_range(0, 15) == 0) ? 2'b11 : 2'($urandom_range(0, 2));
            n  = 1 << sz;
            a  = ($urandom_range(0, 9) == 0) ? $urandom : 32'($urandom_range(0, NBYTES - 1));
            if (sz != 2'b11 && $urandom_range(0, 9) < 7) a = a & ~32'(n - 1);
            applyStimulus("rand", 1'($urandom), sz, 1'($urandom), a, $urandom);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
